// File: rtl/ps2_sched_pkg.sv
// Shared types and constants for the PS/2 command scheduler.
//   state_t  : scheduler FSM states
//   result_t : transaction result codes returned on RESULT
//   PS2_*    : device response bytes of interest
package ps2_sched_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_SEND      = 3'd1,
      ST_WAIT_SENT = 3'd2,
      ST_WAIT_RESP = 3'd3,
      ST_DONE      = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      RES_OK      = 2'b00,
      RES_NAK     = 2'b01,
      RES_ERROR   = 2'b10,
      RES_TIMEOUT = 2'b11
   } result_t;

   localparam logic [7:0] PS2_ACK    = 8'hFA;
   localparam logic [7:0] PS2_RESEND = 8'hFE;
   localparam logic [7:0] PS2_FAIL   = 8'hFC;

endpackage

// File: rtl/ps2_sched_arbiter.sv
// Two-way grant logic for the PS/2 command scheduler.
// Build option: PS2_SCHED_ROUND_ROBIN_EN selects round-robin arbitration;
// otherwise requester 0 has fixed priority.
// Ports:
//   CLK, RESET     : clock, asynchronous active-low reset
//   req_0, req_1   : request levels
//   take           : grant is consumed this cycle (updates last-grant)
//   grant_valid_c  : some request is pending (combinational)
//   grant_id_c     : winning requester (combinational)
module ps2_sched_arbiter (
   input  logic CLK,
   input  logic RESET,
   input  logic req_0,
   input  logic req_1,
   input  logic take,
   output logic grant_valid_c,
   output logic grant_id_c
);

   logic last_q;

   // Last-grant register; resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         last_q <= 1'b1;
      end else if (take && grant_valid_c) begin
         last_q <= grant_id_c;
      end
   end

   assign grant_valid_c = req_0 | req_1;

`ifdef PS2_SCHED_ROUND_ROBIN_EN
   // On a tie, favour the requester that was not served last.
   assign grant_id_c = (req_0 & req_1) ? ~last_q : req_1;
`else
   logic unused_last;
   assign unused_last = last_q;
   assign grant_id_c  = ~req_0;
`endif

endmodule

// File: rtl/ps2_cmd_scheduler.sv
// Shares one PS/2 transmitter/receiver between two command requesters.
// Sends the owner's byte, waits for the response, resends on 0xFE up to
// MAX_RETRY times, and reports a result code with a DONE pulse.
// Build option: PS2_SCHED_ROUND_ROBIN_EN (round-robin arbitration).
// Ports:
//   CLK, RESET               : clock, asynchronous active-low reset
//   REQ_x/BYTE_x/DONE_x      : requester x handshake
//   RESULT, BUSY, GRANT_ID   : transaction status
//   SEND_BYTE, BYTE_TO_SEND  : transmitter strobe and byte
//   BYTE_SENT                : transmitter finished pulse
//   BYTE_READY, BYTE_READ,
//   BYTE_ERROR_CODE          : receiver byte and error status
//   RX_READY_FILT            : BYTE_READY with command responses removed
module ps2_cmd_scheduler
   import ps2_sched_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
   parameter int unsigned MAX_RETRY      = 3
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       REQ_0,
   input  logic [7:0] BYTE_0,
   output logic       DONE_0,
   input  logic       REQ_1,
   input  logic [7:0] BYTE_1,
   output logic       DONE_1,
   output logic [1:0] RESULT,
   output logic       BUSY,
   output logic       GRANT_ID,
   output logic       SEND_BYTE,
   output logic [7:0] BYTE_TO_SEND,
   input  logic       BYTE_SENT,
   input  logic       BYTE_READY,
   input  logic [7:0] BYTE_READ,
   input  logic [1:0] BYTE_ERROR_CODE,
   output logic       RX_READY_FILT
);

   localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

   state_t              state_q, state_d;
   logic [7:0]          byte_q, byte_d;
   logic                grant_q, grant_d;
   logic                busy_q, busy_d;
   logic                send_q, send_d;
   logic                done0_q, done0_d;
   logic                done1_q, done1_d;
   result_t             result_q, result_d;
   logic [RETRY_W-1:0]  retry_q, retry_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;

   logic                fin;
   result_t             fin_res;
   logic                arb_valid_c;
   logic                arb_id_c;

   ps2_sched_arbiter u_arb (
      .CLK           (CLK),
      .RESET         (RESET),
      .req_0         (REQ_0),
      .req_1         (REQ_1),
      .take          (state_q == ST_IDLE),
      .grant_valid_c (arb_valid_c),
      .grant_id_c    (arb_id_c)
   );

   // State and registered outputs.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q  <= ST_IDLE;
         byte_q   <= 8'hFF;
         grant_q  <= 1'b0;
         busy_q   <= 1'b0;
         send_q   <= 1'b0;
         done0_q  <= 1'b0;
         done1_q  <= 1'b0;
         result_q <= RES_OK;
         retry_q  <= '0;
         to_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         byte_q   <= byte_d;
         grant_q  <= grant_d;
         busy_q   <= busy_d;
         send_q   <= send_d;
         done0_q  <= done0_d;
         done1_q  <= done1_d;
         result_q <= result_d;
         retry_q  <= retry_d;
         to_cnt_q <= to_cnt_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      byte_d   = byte_q;
      grant_d  = grant_q;
      busy_d   = busy_q;
      send_d   = 1'b0;
      done0_d  = 1'b0;
      done1_d  = 1'b0;
      result_d = result_q;
      retry_d  = retry_q;
      to_cnt_d = to_cnt_q;
      fin      = 1'b0;
      fin_res  = RES_OK;

      case (state_q)
         ST_IDLE: begin
            if (arb_valid_c) begin
               byte_d   = arb_id_c ? BYTE_1 : BYTE_0;
               grant_d  = arb_id_c;
               busy_d   = 1'b1;
               send_d   = 1'b1;
               to_cnt_d = '0;
               state_d  = ST_SEND;
            end
         end
         // Counter reads 0 in the SEND cycle, so it holds cycles-since-SEND.
         ST_SEND: begin
            to_cnt_d = to_cnt_q + TO_W'(1);
            state_d  = ST_WAIT_SENT;
         end
         ST_WAIT_SENT: begin
            if (to_cnt_q >= TO_LAST) begin
               fin     = 1'b1;
               fin_res = RES_TIMEOUT;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
               if (BYTE_SENT) begin
                  state_d = ST_WAIT_RESP;
               end
            end
         end
         // A received byte takes precedence over a same-cycle timeout.
         ST_WAIT_RESP: begin
            if (BYTE_READY) begin
               fin = 1'b1;
               if (BYTE_ERROR_CODE != 2'b00) begin
                  fin_res = RES_ERROR;
               end else if (BYTE_READ == PS2_ACK) begin
                  fin_res = RES_OK;
               end else if (BYTE_READ == PS2_RESEND) begin
                  if (retry_q < RETRY_LIM) begin
                     fin      = 1'b0;
                     retry_d  = retry_q + RETRY_W'(1);
                     send_d   = 1'b1;
                     to_cnt_d = '0;
                     state_d  = ST_SEND;
                  end else begin
                     fin_res = RES_NAK;
                  end
               end else if (BYTE_READ == PS2_FAIL) begin
                  fin_res = RES_ERROR;
               end else begin
                  fin_res = RES_ERROR;
               end
            end else if (to_cnt_q >= TO_LAST) begin
               fin     = 1'b1;
               fin_res = RES_TIMEOUT;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
         end
         ST_DONE: begin
            busy_d  = 1'b0;
            retry_d = '0;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Close the transaction: pulse the owner's DONE with the result.
      if (fin) begin
         done0_d  = ~grant_q;
         done1_d  = grant_q;
         result_d = fin_res;
         state_d  = ST_DONE;
      end
   end

   assign DONE_0        = done0_q;
   assign DONE_1        = done1_q;
   assign RESULT        = result_q;
   assign BUSY          = busy_q;
   assign GRANT_ID      = grant_q;
   assign SEND_BYTE     = send_q;
   assign BYTE_TO_SEND  = byte_q;
   // Response bytes belong to the scheduler; hide them from packet logic.
   assign RX_READY_FILT = BYTE_READY & RESET & (state_q != ST_WAIT_RESP);

endmodule

// File: doc/ps2_cmd_scheduler.md
Name: ps2_cmd_scheduler

Overview:
Shares the single PS/2 transmitter/receiver pair between two command requesters: requester 0 is the mouse master FSM (reset/stream-enable commands), requester 1 is the CPU-mapped command port. For each command it sends one byte, waits for the device response, retries on resend, and returns a result code to the owning requester. While a response is pending it hides the ACK byte from downstream packet logic.

Parameters:
TIMEOUT_CYCLES, 2_500_000, CLK cycles from SEND_BYTE until the transaction fails with TIMEOUT (50 ms at 50 MHz).
MAX_RETRY, 3, number of resends allowed after a 0xFE response before failing with NAK.

Ports:
CLK  in  1  system clock
RESET  in  1  asynchronous, active-low reset
REQ_0  in  1  requester 0 command request, level, held until DONE_0
BYTE_0  in  8  requester 0 command byte, sampled at grant
DONE_0  out  1  one-cycle pulse: requester 0 transaction finished
REQ_1  in  1  requester 1 command request, level
BYTE_1  in  8  requester 1 command byte
DONE_1  out  1  one-cycle pulse: requester 1 transaction finished
RESULT  out  2  00 OK, 01 NAK, 10 ERROR, 11 TIMEOUT; valid with DONE_x, held until the next DONE
BUSY  out  1  high from grant until the DONE cycle inclusive
GRANT_ID  out  1  owner of the current or last transaction
SEND_BYTE  out  1  one-cycle transmit strobe
BYTE_TO_SEND  out  8  transmit byte
BYTE_SENT  in  1  transmitter finished pulse
BYTE_READY  in  1  receiver byte-valid pulse
BYTE_READ  in  8  received byte
BYTE_ERROR_CODE  in  2  receiver error, nonzero = framing/parity error
RX_READY_FILT  out  1  BYTE_READY with response bytes masked out

Behaviour:
- Reset, asynchronous, active-low: state IDLE; SEND_BYTE, DONE_x, BUSY, GRANT_ID, RX_READY_FILT = 0; RESULT = 00; BYTE_TO_SEND = 8'hFF; retry and timeout counters = 0. Reset asserted mid-transaction aborts it with no DONE.
- States: IDLE, SEND, WAIT_SENT, WAIT_RESP, DONE.
- IDLE: if any REQ is high, arbitrate (fixed priority 0 over 1), latch BYTE_x into BYTE_TO_SEND, set GRANT_ID and BUSY, go to SEND. A REQ dropped before grant is ignored.
- SEND: SEND_BYTE = 1 for exactly this cycle; clear the timeout counter; go to WAIT_SENT.
- WAIT_SENT: on BYTE_SENT go to WAIT_RESP. BYTE_READY here is passed through unmasked.
- WAIT_RESP: on BYTE_READY, evaluated in this order:
  - BYTE_ERROR_CODE != 0: ERROR.
  - 0xFA: OK.
  - 0xFE: if retry count < MAX_RETRY, increment it and go to SEND, resending the same latched byte; otherwise NAK.
  - 0xFC or any other byte: ERROR.
- RX_READY_FILT = BYTE_READY & (state != WAIT_RESP), combinational.
- The timeout counter runs in WAIT_SENT and WAIT_RESP, is cleared in SEND, and reaching TIMEOUT_CYCLES-1 ends the transaction with TIMEOUT. If BYTE_READY and timeout occur in the same cycle, BYTE_READY wins.
- DONE: pulse DONE_x of the owner; RESULT registered; retry count cleared; BUSY deasserts next cycle; return to IDLE.
- Minimum one IDLE cycle between transactions. A REQ still high after DONE starts a new transaction.
- Latency: REQ high in IDLE at cycle n gives SEND_BYTE at n+1. Final BYTE_READY at cycle m gives DONE_x at m+1.

Optional Feature:
PS2_SCHED_ROUND_ROBIN_EN:
- Defined: round-robin arbitration. When both REQs are high, grant the requester not granted last; the last-grant register resets to 1, so requester 0 wins first.
- Undefined: fixed priority, requester 0 always wins.

Decomposition:
- Package ps2_sched_pkg holds:
  - state enum;
  - result enum (RES_OK, RES_NAK, RES_ERROR, RES_TIMEOUT);
  - response constants PS2_ACK=8'hFA, PS2_RESEND=8'hFE, PS2_FAIL=8'hFC.
- Sub-module ps2_sched_arbiter: 2-way fixed/round-robin grant logic with last-grant register, so the arbitration policy is testable in isolation.

Test Plan:
- REQ_0=1, BYTE_0=8'hFF, BYTE_SENT after 10 cycles, then BYTE_READY with 8'hFA -> one SEND_BYTE with BYTE_TO_SEND=FF; DONE_0 pulse; RESULT=00; RX_READY_FILT stays 0 for the FA byte.
- REQ_1=1, BYTE_1=8'hF4, device answers FE three times then FA -> four SEND_BYTE pulses, all F4; DONE_1; RESULT=00. With four FE responses -> RESULT=01 after the fourth FE.
- REQ_0=1 and REQ_1=1 in the same cycle, both serviced -> fixed mode: grants 0 then 1. With PS2_SCHED_ROUND_ROBIN_EN and both held for four transactions: 0,1,0,1.
- No BYTE_READY after BYTE_SENT, TIMEOUT_CYCLES=100 -> DONE at 100 cycles after SEND; RESULT=11; BUSY drops next cycle.
- BYTE_READY with BYTE_ERROR_CODE=2'b01 in WAIT_RESP -> RESULT=10. BYTE_READY in IDLE -> RX_READY_FILT=1.
- RESET low during WAIT_RESP -> all outputs at reset values immediately; no DONE; a new REQ after release starts cleanly with retry count 0.
